// File: rtl/interrupt_flag_capture.sv
// Purpose: capture peripheral events into sticky/level flags and run the interrupt/ack handshake.
// Latency: int_src edge -> flag after SYNC_STAGES+1 clocks, interrupt one clock later.
// Backpressure: a request is held until acked or until pending drops; new events stay sticky.
module interrupt_flag_capture #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic [NUM_SRC-1:0] int_edge_cfg,
    input  logic [NUM_SRC-1:0] int_enable,
    input  logic [NUM_SRC-1:0] int_clear,
    input  logic               int_clear_stb,
    output logic [NUM_SRC-1:0] int_flags,
    output logic               interrupt,
    input  logic               interrupt_ack,
    output logic [2:0]         int_id,
    output logic               int_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t state_q, state_nxt;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] flags_nxt;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] id_mask;
    logic [2:0]         sel;
    logic               id_flag;
    logic               id_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= int_src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Edge bits: a fresh rising edge overrides a same-cycle clear so no event is lost.
    assign clr_mask  = int_clear_stb ? int_clear : '0;
    assign flags_nxt = (int_edge_cfg & ((int_flags & ~clr_mask) | (s & ~prev_q)))
                     | (~int_edge_cfg & s);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_flags <= '0;
        end else begin
            int_flags <= flags_nxt;
        end
    end

    assign pending = int_flags & int_enable;

    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = 3'(i);
            end
        end
    end

    assign id_mask = NUM_SRC'(1) << int_id;
    assign id_flag = |(int_flags & id_mask);

    // An ack is only honoured while something is actually pending, so int_id always names a real source.
    always_comb begin
        state_nxt = state_q;
        id_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending != '0) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (interrupt_ack && (pending != '0)) begin
                    state_nxt = SERVICE;
                    id_load   = 1'b1;
                end else if (pending == '0) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (!id_flag) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            int_id  <= '0;
        end else begin
            state_q <= state_nxt;
            if (id_load) begin
                int_id <= sel;
            end
        end
    end

    assign interrupt = (state_q == REQ);
    assign int_busy  = (state_q == SERVICE);

endmodule

// File: tb/tb_interrupt_flag_capture.sv
// Bench for interrupt_flag_capture: directed vector table, corner sequences, random run against a model.
module tb_interrupt_flag_capture;

    localparam int NS = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [NS-1:0] int_src = '0;
    logic [NS-1:0] int_edge_cfg = '0;
    logic [NS-1:0] int_enable = '0;
    logic [NS-1:0] int_clear = '0;
    logic          int_clear_stb = 1'b0;
    logic [NS-1:0] int_flags;
    logic          interrupt;
    logic          interrupt_ack = 1'b0;
    logic [2:0]    int_id;
    logic          int_busy;

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_flag_capture #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .int_src       (int_src),
        .int_edge_cfg  (int_edge_cfg),
        .int_enable    (int_enable),
        .int_clear     (int_clear),
        .int_clear_stb (int_clear_stb),
        .int_flags     (int_flags),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .int_id        (int_id),
        .int_busy      (int_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] src;
        logic [7:0] cfg;
        logic [7:0] en;
        logic [7:0] clr;
        logic       stb;
        logic       ack;
        logic [7:0] e_flags;
        logic       e_irq;
        logic [2:0] e_id;
        logic       e_busy;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        int_src       = '0;
        int_edge_cfg  = '0;
        int_enable    = '0;
        int_clear     = '0;
        int_clear_stb = 1'b0;
        interrupt_ack = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic cur(input int which);
        return (which == 0) ? interrupt : int_busy;
    endfunction

    // Bounded wait: a timeout shows up as a failed comparison.
    task automatic wait_sig(input int which, input logic val, input int budget, input string name);
        int k;
        k = 0;
        while (cur(which) !== val && k < budget) begin
            tick();
            k++;
        end
        check(name, cur(which), val);
    endtask

    // Reference model: sample history queue plus request/service/gap bookkeeping.
    logic [7:0] m_hist [$];
    logic [7:0] m_flags;
    bit         m_req, m_srv, m_gap;
    logic [2:0] m_id;

    function automatic logic [2:0] lowest(input logic [7:0] p);
        for (int i = 0; i < NS; i++) begin
            if (p[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic m_reset();
        m_hist = {};
        for (int i = 0; i <= SS; i++) m_hist.push_back(8'h00);
        m_flags = '0;
        m_req = 0; m_srv = 0; m_gap = 0;
        m_id = '0;
    endtask

    task automatic m_step(input logic [7:0] src, input logic [7:0] cfg, input logic [7:0] en,
                          input logic [7:0] clr, input logic stb, input logic ack);
        logic [7:0] s_o, p_o, pend, nf;
        s_o  = m_hist[SS-1];
        p_o  = m_hist[SS];
        pend = m_flags & en;
        for (int i = 0; i < NS; i++) begin
            if (cfg[i]) nf[i] = (s_o[i] && !p_o[i]) ? 1'b1 : ((stb && clr[i]) ? 1'b0 : m_flags[i]);
            else        nf[i] = s_o[i];
        end
        if (m_req) begin
            if (ack && pend != 0) begin
                m_req = 0; m_srv = 1; m_id = lowest(pend);
            end else if (pend == 0) begin
                m_req = 0;
            end
        end else if (m_srv) begin
            if (!m_flags[m_id]) begin
                m_srv = 0; m_gap = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (pend != 0) begin
            m_req = 1;
        end
        m_flags = nf;
        m_hist.push_front(src);
        void'(m_hist.pop_back());
    endtask

    initial begin
        logic [7:0] r_src, r_cfg, r_en, r_clr;
        logic       r_stb, r_ack;
        int         k;

        // edge-sticky single source, handshake and W1C, then set-beats-clear on bit 3
        tbl[0]  = '{8'h04, 8'hFF, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{8'h00, 8'hFF, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{8'h00, 8'hFF, 8'h04, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{8'h00, 8'hFF, 8'h04, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 3'd0, 1'b0};
        tbl[4]  = '{8'h00, 8'hFF, 8'h04, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 3'd0, 1'b0};
        tbl[5]  = '{8'h00, 8'hFF, 8'h04, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 3'd2, 1'b1};
        tbl[6]  = '{8'h00, 8'hFF, 8'h04, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 3'd2, 1'b1};
        tbl[7]  = '{8'h00, 8'hFF, 8'h04, 8'h04, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 1'b1};
        tbl[8]  = '{8'h00, 8'hFF, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[9]  = '{8'h00, 8'hFF, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[10] = '{8'h08, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[11] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[12] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd2, 1'b0};
        tbl[13] = '{8'h08, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd2, 1'b0};
        tbl[14] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd2, 1'b0};
        tbl[15] = '{8'h00, 8'hFF, 8'h00, 8'h08, 1'b1, 1'b0, 8'h08, 1'b0, 3'd2, 1'b0};
        tbl[16] = '{8'h00, 8'hFF, 8'h00, 8'h08, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};

        // reset values, before any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        check("reset flags", int_flags, 0);
        check("reset irq", interrupt, 0);
        check("reset id", int_id, 0);
        check("reset busy", int_busy, 0);
        reset_n = 1'b1;
        tick();

        // asynchronous reset in the middle of a request
        do_reset();
        int_edge_cfg = 8'hFF; int_enable = 8'h01; int_src = 8'h01;
        tick();
        int_src = 8'h00;
        wait_sig(0, 1'b1, 10, "t1 irq raised");
        #2;
        reset_n = 1'b0;
        #1;
        check("t1 async irq", interrupt, 0);
        check("t1 async flags", int_flags, 0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("t1 post irq", interrupt, 0);
        check("t1 post flags", int_flags, 0);
        check("t1 post busy", int_busy, 0);

        // vector table
        do_reset();
        for (int r = 0; r < 17; r++) begin
            int_src = tbl[r].src; int_edge_cfg = tbl[r].cfg; int_enable = tbl[r].en;
            int_clear = tbl[r].clr; int_clear_stb = tbl[r].stb; interrupt_ack = tbl[r].ack;
            tick();
            check($sformatf("vec%0d flags", r), int_flags, tbl[r].e_flags);
            check($sformatf("vec%0d irq", r), interrupt, tbl[r].e_irq);
            check($sformatf("vec%0d id", r), int_id, tbl[r].e_id);
            check($sformatf("vec%0d busy", r), int_busy, tbl[r].e_busy);
        end
        drive_idle();

        // two simultaneous sources: lowest index first, then the other
        do_reset();
        int_edge_cfg = 8'hFF; int_enable = 8'hFF; int_src = 8'h22;
        tick();
        int_src = 8'h00;
        wait_sig(0, 1'b1, 10, "t3 irq first");
        check("t3 flags both", int_flags, 8'h22);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        check("t3 first id", int_id, 1);
        check("t3 busy", int_busy, 1);
        int_clear = 8'h02; int_clear_stb = 1'b1;
        tick();
        int_clear_stb = 1'b0;
        wait_sig(1, 1'b0, 5, "t3 service exit");
        wait_sig(0, 1'b1, 10, "t3 irq second");
        check("t3 flags remain", int_flags, 8'h20);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        check("t3 second id", int_id, 5);
        int_clear = 8'h20; int_clear_stb = 1'b1;
        tick();
        int_clear_stb = 1'b0;
        wait_sig(1, 1'b0, 5, "t3 second exit");

        // level source ignores W1C; service ends only when the source drops
        do_reset();
        int_edge_cfg = 8'h00; int_enable = 8'h01; int_src = 8'h01;
        wait_sig(0, 1'b1, 10, "t5 irq");
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        check("t5 busy", int_busy, 1);
        int_clear = 8'h01; int_clear_stb = 1'b1;
        tick();
        int_clear_stb = 1'b0;
        repeat (3) tick();
        check("t5 busy after w1c", int_busy, 1);
        check("t5 flag after w1c", int_flags, 8'h01);
        int_src = 8'h00;
        k = 0;
        while (int_flags[0] === 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("t5 level fall latency", k, SS + 1);
        tick();
        check("t5 hold busy", int_busy, 0);
        check("t5 hold irq", interrupt, 0);

        // request withdrawn by disabling; stray ack ignored
        do_reset();
        int_edge_cfg = 8'hFF; int_enable = 8'h01; int_src = 8'h01;
        tick();
        int_src = 8'h00;
        wait_sig(0, 1'b1, 10, "t6 irq");
        int_enable = 8'h00;
        tick();
        check("t6 irq withdrawn", interrupt, 0);
        check("t6 flags kept", int_flags, 8'h01);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        tick();
        check("t6 stray ack irq", interrupt, 0);
        check("t6 stray ack busy", int_busy, 0);
        check("t6 stray ack id", int_id, 0);
        int_enable = 8'h01;
        tick();
        check("t6 re-request", interrupt, 1);

        // random run against the model
        do_reset();
        m_reset();
        r_src = '0; r_cfg = '0; r_en = '0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 0) r_cfg = 8'($urandom);
            if ($urandom_range(0, 19) == 0) r_en = 8'($urandom);
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(0, 7) == 0) r_src[b] = ~r_src[b];
            end
            r_stb = ($urandom_range(0, 5) == 0);
            r_clr = 8'($urandom);
            if (m_srv && $urandom_range(0, 3) == 0) begin
                r_stb = 1'b1;
                r_clr = 8'h01 << m_id;
            end
            r_ack = m_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            int_src = r_src; int_edge_cfg = r_cfg; int_enable = r_en;
            int_clear = r_clr; int_clear_stb = r_stb; interrupt_ack = r_ack;
            m_step(r_src, r_cfg, r_en, r_clr, r_stb, r_ack);
            tick();
            check($sformatf("rnd%0d flags", c), int_flags, m_flags);
            check($sformatf("rnd%0d irq", c), interrupt, m_req);
            check($sformatf("rnd%0d id", c), int_id, m_id);
            check($sformatf("rnd%0d busy", c), int_busy, m_srv);
        end
        drive_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
